// File: rtl/vga_scan_compositor_pkg.sv
// rtl/vga_scan_compositor_pkg.sv - shared defines, VGA timing defaults, layer enum and colour-bar helper
`ifndef VGA_SCAN_COMPOSITOR_DEFINES
`define VGA_SCAN_COMPOSITOR_DEFINES
`define COLOR_RGB_DEPTH     12
`define H_DISP_LEN          10
`define V_DISP_LEN          10
`define GAME_STATUS_BIT_LEN 2
`define GAME_STATUS_RUN     2'd1
`define H_DISP              640
`define H_FP                16
`define H_SYNC              96
`define H_BP                48
`define H_TOTAL             (`H_DISP + `H_FP + `H_SYNC + `H_BP)
`define V_DISP              480
`define V_FP                10
`define V_SYNC              2
`define V_BP                33
`define V_TOTAL             (`V_DISP + `V_FP + `V_SYNC + `V_BP)
`define LAYER_DLY           2
`define BAR_WIDTH           80
`define BAR_WHITE           12'hFFF
`define BAR_YELLOW          12'hFF0
`define BAR_CYAN            12'h0FF
`define BAR_GREEN           12'h0F0
`define BAR_MAGENTA         12'hF0F
`define BAR_RED             12'hF00
`define BAR_BLUE            12'h00F
`define BAR_BLACK           12'h000
`endif

package vga_scan_compositor_pkg;

  localparam int H_DISP_DEF    = `H_DISP;
  localparam int H_FP_DEF      = `H_FP;
  localparam int H_SYNC_DEF    = `H_SYNC;
  localparam int H_BP_DEF      = `H_BP;
  localparam int V_DISP_DEF    = `V_DISP;
  localparam int V_FP_DEF      = `V_FP;
  localparam int V_SYNC_DEF    = `V_SYNC;
  localparam int V_BP_DEF      = `V_BP;
  localparam int LAYER_DLY_DEF = `LAYER_DLY;

  typedef logic [`COLOR_RGB_DEPTH-1:0] rgb_t;

  // Which layer wins the composite at a given pixel, ordered by rising priority
  typedef enum logic [1:0] {
    LAYER_BG     = 2'd0,
    LAYER_ENEMY  = 2'd1,
    LAYER_BULLET = 2'd2,
    LAYER_ME     = 2'd3
  } layer_e;

  // Eight vertical bars of BAR_WIDTH pixels, left to right
  function automatic rgb_t bar_color(input logic [9:0] x);
    rgb_t c;
    if      (x < 10'(1 * `BAR_WIDTH)) c = `BAR_WHITE;
    else if (x < 10'(2 * `BAR_WIDTH)) c = `BAR_YELLOW;
    else if (x < 10'(3 * `BAR_WIDTH)) c = `BAR_CYAN;
    else if (x < 10'(4 * `BAR_WIDTH)) c = `BAR_GREEN;
    else if (x < 10'(5 * `BAR_WIDTH)) c = `BAR_MAGENTA;
    else if (x < 10'(6 * `BAR_WIDTH)) c = `BAR_RED;
    else if (x < 10'(7 * `BAR_WIDTH)) c = `BAR_BLUE;
    else                              c = `BAR_BLACK;
    return c;
  endfunction

endpackage

// File: rtl/vga_scan_compositor_if.sv
// rtl/vga_scan_compositor_if.sv - layer pixel interface between the compositor and the sprite/background layers
interface vga_scan_compositor_if;

  logic [`H_DISP_LEN-1:0]      req_x_addr_o;
  logic [`V_DISP_LEN-1:0]      req_y_addr_o;
  logic                        frame_start_o;
  logic                        crash_enemy_bullet_o;
  logic                        crash_me_enemy_o;
  logic [`COLOR_RGB_DEPTH-1:0] me_rgb_i;
  logic                        me_alpha_i;
  logic [`COLOR_RGB_DEPTH-1:0] bullet_rgb_i;
  logic                        bullet_alpha_i;
  logic [`COLOR_RGB_DEPTH-1:0] enemy_rgb_i;
  logic                        enemy_alpha_i;
  logic [`COLOR_RGB_DEPTH-1:0] bg_rgb_i;

  modport master (
    output req_x_addr_o, req_y_addr_o, frame_start_o,
    output crash_enemy_bullet_o, crash_me_enemy_o,
    input  me_rgb_i, me_alpha_i, bullet_rgb_i, bullet_alpha_i,
    input  enemy_rgb_i, enemy_alpha_i, bg_rgb_i
  );

  modport slave (
    input  req_x_addr_o, req_y_addr_o, frame_start_o,
    input  crash_enemy_bullet_o, crash_me_enemy_o,
    output me_rgb_i, me_alpha_i, bullet_rgb_i, bullet_alpha_i,
    output enemy_rgb_i, enemy_alpha_i, bg_rgb_i
  );

endinterface

// File: rtl/vga_scan_compositor_timing.sv
// rtl/vga_scan_compositor_timing.sv - vga_timing_gen: h/v counters, raw sync flags, active flag and frame_start
module vga_timing_gen #(
  parameter int H_DISP = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_DISP = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       active_o,
  output logic       hsync_act_o,
  output logic       vsync_act_o,
  output logic       frame_start_o
);

  localparam logic [9:0] H_LAST     = 10'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_DISP);
  localparam logic [9:0] V_ACT_END  = 10'(V_DISP);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_DISP + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_DISP + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_DISP + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       frame_start_q, frame_start_d;

  // Raster advance: wrap h at end of line, step v on wrap; explicit compares avoid relying on overflow
  always_comb begin
    h_cnt_d       = h_cnt_q + 10'd1;
    v_cnt_d       = v_cnt_q;
    frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) v_cnt_d = 10'd0;
      else                   v_cnt_d = v_cnt_q + 10'd1;
    end
  end

  // Counter and frame-start registers; reset restarts a full frame from 0,0
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign active_o      = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
  assign hsync_act_o   = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
  assign vsync_act_o   = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_scan_compositor.sv
// rtl/vga_scan_compositor.sv - raster requester, layer alignment pipeline and priority compositor; optional COMPOSITOR_TEST_PATTERN_EN
module vga_scan_compositor
  import vga_scan_compositor_pkg::*;
#(
  parameter int H_DISP    = H_DISP_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_DISP    = V_DISP_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int LAYER_DLY = LAYER_DLY_DEF
) (
  input  logic                           clk_vga,
  input  logic                           rst_n,
`ifdef COMPOSITOR_TEST_PATTERN_EN
  input  logic                           test_pattern_i,
`endif
  input  logic [`GAME_STATUS_BIT_LEN-1:0] game_status_i,
  vga_scan_compositor_if.master          layer_if,
  output logic                           hsync_o,
  output logic                           vsync_o,
  output logic [`COLOR_RGB_DEPTH-1:0]    vga_rgb_o
);

  logic [9:0] h_cnt, v_cnt;
  logic       active_0, hsync_act, vsync_act, frame_start;

  vga_timing_gen #(
    .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_vga       (clk_vga),
    .rst_n         (rst_n),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .active_o      (active_0),
    .hsync_act_o   (hsync_act),
    .vsync_act_o   (vsync_act),
    .frame_start_o (frame_start)
  );

  assign layer_if.req_x_addr_o  = active_0 ? h_cnt : '0;
  assign layer_if.req_y_addr_o  = active_0 ? v_cnt : '0;
  assign layer_if.frame_start_o = frame_start;

  // Sync flags are carried active-high so an all-zero reset never produces a sync pulse
  logic [LAYER_DLY-1:0] active_pipe_q, active_pipe_d;
  logic [LAYER_DLY-1:0] hs_pipe_q, hs_pipe_d;
  logic [LAYER_DLY-1:0] vs_pipe_q, vs_pipe_d;
  logic                 active_dly;

  // Shift counter-domain flags so stage LAYER_DLY-1 lines up with the layer data
  always_comb begin
    active_pipe_d    = active_pipe_q;
    hs_pipe_d        = hs_pipe_q;
    vs_pipe_d        = vs_pipe_q;
    active_pipe_d[0] = active_0;
    hs_pipe_d[0]     = hsync_act;
    vs_pipe_d[0]     = vsync_act;
    for (int i = 1; i < LAYER_DLY; i++) begin
      active_pipe_d[i] = active_pipe_q[i-1];
      hs_pipe_d[i]     = hs_pipe_q[i-1];
      vs_pipe_d[i]     = vs_pipe_q[i-1];
    end
  end

  assign active_dly = active_pipe_q[LAYER_DLY-1];

`ifdef COMPOSITOR_TEST_PATTERN_EN
  logic [9:0] x_pipe_q [LAYER_DLY];
  logic [9:0] x_pipe_d [LAYER_DLY];

  // Column pipeline so the bar colour follows the same pixel as active_dly
  always_comb begin
    x_pipe_d    = x_pipe_q;
    x_pipe_d[0] = h_cnt;
    for (int i = 1; i < LAYER_DLY; i++) x_pipe_d[i] = x_pipe_q[i-1];
  end

  // Column pipeline registers
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAYER_DLY; i++) x_pipe_q[i] <= 10'd0;
    end else begin
      x_pipe_q <= x_pipe_d;
    end
  end
`endif

  logic   run, me_a, bul_a, en_a;
  layer_e sel;
  rgb_t   winner, rgb_d;
  logic   crash_eb, crash_me;

  // Priority composite me > bullet > enemy > bg; sprite layers vanish outside RUN
  always_comb begin
    run   = (game_status_i == `GAME_STATUS_RUN);
    me_a  = run & layer_if.me_alpha_i;
    bul_a = run & layer_if.bullet_alpha_i;
    en_a  = run & layer_if.enemy_alpha_i;
    sel   = LAYER_BG;
    if (en_a)  sel = LAYER_ENEMY;
    if (bul_a) sel = LAYER_BULLET;
    if (me_a)  sel = LAYER_ME;
    case (sel)
      LAYER_ME:     winner = layer_if.me_rgb_i;
      LAYER_BULLET: winner = layer_if.bullet_rgb_i;
      LAYER_ENEMY:  winner = layer_if.enemy_rgb_i;
      default:      winner = layer_if.bg_rgb_i;
    endcase
    rgb_d    = active_dly ? winner : '0;
    crash_eb = active_dly & en_a & bul_a;
    crash_me = active_dly & me_a & en_a;
`ifdef COMPOSITOR_TEST_PATTERN_EN
    if (test_pattern_i) begin
      rgb_d    = active_dly ? bar_color(x_pipe_q[LAYER_DLY-1]) : '0;
      crash_eb = 1'b0;
      crash_me = 1'b0;
    end
`endif
  end

  // Strobes stay combinational so layers see them on the edge that closes their delayed pixel
  assign layer_if.crash_enemy_bullet_o = crash_eb;
  assign layer_if.crash_me_enemy_o     = crash_me;

  logic hsync_q, vsync_q;
  rgb_t rgb_q;

  // Alignment pipeline plus pin registers; syncs and colour leave in the same stage
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      active_pipe_q <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= '0;
    end else begin
      active_pipe_q <= active_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      hsync_q       <= ~hs_pipe_q[LAYER_DLY-1];
      vsync_q       <= ~vs_pipe_q[LAYER_DLY-1];
      rgb_q         <= rgb_d;
    end
  end

  assign hsync_o   = hsync_q;
  assign vsync_o   = vsync_q;
  assign vga_rgb_o = rgb_q;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// tb/tb_vga_scan_compositor.sv - directed self-checking bench for vga_scan_compositor (shortened vertical frame)
module tb_vga_scan_compositor;

  localparam int TB_V_DISP = 24;
  localparam int TB_V_FP   = 2;
  localparam int TB_V_SYNC = 2;
  localparam int TB_V_BP   = 2;

  logic        clk_vga = 1'b0;
  logic        rst_n   = 1'b0;
  logic [1:0]  game_status = 2'd1;
  logic        tp = 1'b0;
  logic        hsync, vsync;
  logic [11:0] rgb;

  int n_cmp = 0;
  int n_err = 0;
  int ecount = 0;

  logic       me_en = 1'b0, bul_en = 1'b0, en_en = 1'b0;
  logic [9:0] lx1 = '0, lx2 = '0, ly1 = '0, ly2 = '0;
  logic       pix_win, crash_win;

  vga_scan_compositor_if lif();

  vga_scan_compositor #(
    .V_DISP(TB_V_DISP), .V_FP(TB_V_FP), .V_SYNC(TB_V_SYNC), .V_BP(TB_V_BP)
  ) dut (
    .clk_vga       (clk_vga),
    .rst_n         (rst_n),
`ifdef COMPOSITOR_TEST_PATTERN_EN
    .test_pattern_i(tp),
`endif
    .game_status_i (game_status),
    .layer_if      (lif),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .vga_rgb_o     (rgb)
  );

  always #20 clk_vga = ~clk_vga;

  always @(posedge clk_vga) begin
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  always @(posedge clk_vga) begin
    lx1 <= lif.req_x_addr_o;
    lx2 <= lx1;
    ly1 <= lif.req_y_addr_o;
    ly2 <= ly1;
  end

  always_comb begin
    pix_win   = (lx2 >= 10'd100) && (lx2 <= 10'd103) && (ly2 == 10'd10);
    crash_win = (lx2 == 10'd200) && (ly2 == 10'd20);
    lif.me_alpha_i     = me_en && pix_win;
    lif.bullet_alpha_i = bul_en && (pix_win || crash_win);
    lif.enemy_alpha_i  = en_en && (pix_win || crash_win);
  end

  assign lif.me_rgb_i     = 12'hF00;
  assign lif.bullet_rgb_i = 12'h0F0;
  assign lif.enemy_rgb_i  = 12'h00F;
  assign lif.bg_rgb_i     = 12'h555;

  task automatic goto(input int k);
    int guard;
    guard = 0;
    while (ecount < k && guard < 100000) begin
      @(negedge clk_vga);
      guard++;
    end
    if (ecount != k) begin
      n_cmp++; n_err++;
      $display("FAIL goto: cycle=%0d target=%0d", ecount, k);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(negedge clk_vga);
    n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    n_cmp++; if (lif.frame_start_o !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", lif.frame_start_o); end
    n_cmp++; if (lif.crash_enemy_bullet_o !== 1'b0) begin n_err++; $display("FAIL reset_crash_eb: got %b want 0", lif.crash_enemy_bullet_o); end
    n_cmp++; if (lif.crash_me_enemy_o !== 1'b0) begin n_err++; $display("FAIL reset_crash_me: got %b want 0", lif.crash_me_enemy_o); end
    rst_n = 1'b1;
    n_cmp++; if (lif.req_x_addr_o !== 10'd0) begin n_err++; $display("FAIL reset_reqx: got %0d want 0", lif.req_x_addr_o); end
    goto(1);
    n_cmp++; if (lif.frame_start_o !== 1'b1) begin n_err++; $display("FAIL fs_first: got %b want 1", lif.frame_start_o); end
    n_cmp++; if (lif.req_x_addr_o !== 10'd1) begin n_err++; $display("FAIL reqx_1: got %0d want 1", lif.req_x_addr_o); end
    goto(2);
    n_cmp++; if (lif.frame_start_o !== 1'b0) begin n_err++; $display("FAIL fs_one_cycle: got %b want 0", lif.frame_start_o); end
  endtask

  task automatic test_hsync;
    goto(103);
    n_cmp++; if (rgb !== 12'h555) begin n_err++; $display("FAIL bg_pixel: got %h want 555", rgb); end
    goto(658);
    n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("FAIL hs_658: got %b want 1", hsync); end
    goto(659);
    n_cmp++; if (hsync !== 1'b0) begin n_err++; $display("FAIL hs_659: got %b want 0", hsync); end
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL hblank_rgb: got %h want 000", rgb); end
    goto(754);
    n_cmp++; if (hsync !== 1'b0) begin n_err++; $display("FAIL hs_754: got %b want 0", hsync); end
    goto(755);
    n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("FAIL hs_755: got %b want 1", hsync); end
    goto(1458);
    n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("FAIL hs_1458: got %b want 1", hsync); end
    goto(1459);
    n_cmp++; if (hsync !== 1'b0) begin n_err++; $display("FAIL hs_1459: got %b want 0", hsync); end
  endtask

  task automatic test_priority;
    me_en = 1'b1; bul_en = 1'b1; en_en = 1'b1;
    goto(8103);
    n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL prio_me: got %h want F00", rgb); end
    me_en = 1'b0;
    goto(8104);
    n_cmp++; if (rgb !== 12'h0F0) begin n_err++; $display("FAIL prio_bullet: got %h want 0F0", rgb); end
    bul_en = 1'b0;
    goto(8105);
    n_cmp++; if (rgb !== 12'h00F) begin n_err++; $display("FAIL prio_enemy: got %h want 00F", rgb); end
    en_en = 1'b0;
    goto(8106);
    n_cmp++; if (rgb !== 12'h555) begin n_err++; $display("FAIL prio_bg: got %h want 555", rgb); end
    goto(8703);
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL blank_700: got %h want 000", rgb); end
  endtask

  task automatic test_crash;
    me_en = 1'b1; bul_en = 1'b1; en_en = 1'b1;
    goto(16201);
    n_cmp++; if (lif.crash_enemy_bullet_o !== 1'b0) begin n_err++; $display("FAIL crash_pre: got %b want 0", lif.crash_enemy_bullet_o); end
    goto(16202);
    n_cmp++; if (lif.crash_enemy_bullet_o !== 1'b1) begin n_err++; $display("FAIL crash_hit: got %b want 1", lif.crash_enemy_bullet_o); end
    n_cmp++; if (lif.crash_me_enemy_o !== 1'b0) begin n_err++; $display("FAIL crash_me_quiet: got %b want 0", lif.crash_me_enemy_o); end
    goto(16203);
    n_cmp++; if (lif.crash_enemy_bullet_o !== 1'b0) begin n_err++; $display("FAIL crash_post: got %b want 0", lif.crash_enemy_bullet_o); end
    n_cmp++; if (rgb !== 12'h0F0) begin n_err++; $display("FAIL crash_pixel: got %h want 0F0", rgb); end
  endtask

  task automatic test_vsync_frame;
    goto(20103);
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL vblank_rgb: got %h want 000", rgb); end
    goto(20802);
    n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("FAIL vs_pre: got %b want 1", vsync); end
    goto(20803);
    n_cmp++; if (vsync !== 1'b0) begin n_err++; $display("FAIL vs_start: got %b want 0", vsync); end
    goto(22402);
    n_cmp++; if (vsync !== 1'b0) begin n_err++; $display("FAIL vs_last: got %b want 0", vsync); end
    goto(22403);
    n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("FAIL vs_end: got %b want 1", vsync); end
    goto(24000);
    n_cmp++; if (lif.frame_start_o !== 1'b0) begin n_err++; $display("FAIL fs_pre: got %b want 0", lif.frame_start_o); end
    goto(24001);
    n_cmp++; if (lif.frame_start_o !== 1'b1) begin n_err++; $display("FAIL fs_period: got %b want 1", lif.frame_start_o); end
    goto(24002);
    n_cmp++; if (lif.frame_start_o !== 1'b0) begin n_err++; $display("FAIL fs_post: got %b want 0", lif.frame_start_o); end
    n_cmp++; if (lif.req_x_addr_o !== 10'd2) begin n_err++; $display("FAIL reqx_wrap: got %0d want 2", lif.req_x_addr_o); end
  endtask

  task automatic test_not_run;
    game_status = 2'd0;
    goto(32103);
    n_cmp++; if (rgb !== 12'h555) begin n_err++; $display("FAIL norun_pixel: got %h want 555", rgb); end
    goto(40202);
    n_cmp++; if (lif.crash_enemy_bullet_o !== 1'b0) begin n_err++; $display("FAIL norun_crash: got %b want 0", lif.crash_enemy_bullet_o); end
    goto(40203);
    n_cmp++; if (rgb !== 12'h555) begin n_err++; $display("FAIL norun_crash_pixel: got %h want 555", rgb); end
  endtask

  task automatic test_midline_reset;
    goto(48400);
    n_cmp++; if (rgb !== 12'h555) begin n_err++; $display("FAIL pre_reset_rgb: got %h want 555", rgb); end
    #5;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL async_rgb: got %h want 000", rgb); end
    n_cmp++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_err++; $display("FAIL async_sync: got %b%b want 11", hsync, vsync); end
    n_cmp++; if (lif.req_x_addr_o !== 10'd0) begin n_err++; $display("FAIL async_reqx: got %0d want 0", lif.req_x_addr_o); end
    repeat (3) @(negedge clk_vga);
    rst_n = 1'b1;
    n_cmp++; if (lif.req_x_addr_o !== 10'd0) begin n_err++; $display("FAIL rel_reqx: got %0d want 0", lif.req_x_addr_o); end
    goto(1);
    n_cmp++; if (lif.frame_start_o !== 1'b1) begin n_err++; $display("FAIL rel_fs: got %b want 1", lif.frame_start_o); end
    goto(658);
    n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("FAIL rel_hs_658: got %b want 1", hsync); end
    goto(659);
    n_cmp++; if (hsync !== 1'b0) begin n_err++; $display("FAIL rel_hs_659: got %b want 0", hsync); end
  endtask

`ifdef COMPOSITOR_TEST_PATTERN_EN
  task automatic test_pattern;
    game_status = 2'd1;
    me_en = 1'b1; bul_en = 1'b1; en_en = 1'b1;
    tp = 1'b1;
    goto(803);
    n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL tp_x0: got %h want FFF", rgb); end
    goto(882);
    n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL tp_x79: got %h want FFF", rgb); end
    goto(883);
    n_cmp++; if (rgb !== 12'hFF0) begin n_err++; $display("FAIL tp_x80: got %h want FF0", rgb); end
    goto(1103);
    n_cmp++; if (rgb !== 12'h0F0) begin n_err++; $display("FAIL tp_x300: got %h want 0F0", rgb); end
    goto(1362);
    n_cmp++; if (rgb !== 12'h00F) begin n_err++; $display("FAIL tp_x559: got %h want 00F", rgb); end
    goto(1363);
    n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL tp_x560: got %h want 000", rgb); end
    goto(16202);
    n_cmp++; if (lif.crash_enemy_bullet_o !== 1'b0) begin n_err++; $display("FAIL tp_crash_eb: got %b want 0", lif.crash_enemy_bullet_o); end
    tp = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_hsync();
    test_priority();
    test_crash();
    test_vsync_frame();
    test_not_run();
    test_midline_reset();
`ifdef COMPOSITOR_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
